// File: rtl/tt_sweep_reader.sv
// Sequential truth-table reader: sweeps every input vector into a combinational netlist,
// samples its output and compares the measured table against a latched expected code.
// Optional build macro TT_SWEEP_MAJORITY_EN: 2-of-3 majority over three samples per vector.
module tt_sweep_reader #(
    parameter int unsigned N_IN          = 3,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [(1<<N_IN)-1:0]    expected,
    output logic [N_IN-1:0]         dut_in,
    input  logic                    dut_out,
    output logic                    busy,
    output logic                    done,
    output logic [(1<<N_IN)-1:0]    table_out,
    output logic                    match,
    output logic [N_IN-1:0]         first_mismatch_idx
);

    localparam int unsigned TW = 1 << N_IN;
    localparam logic [N_IN-1:0]  LastIdx   = '1;
    localparam logic [CNT_W-1:0] SampleCnt = CNT_W'(SETTLE_CYCLES);
`ifdef TT_SWEEP_MAJORITY_EN
    localparam logic [CNT_W-1:0] SecondCnt = CNT_W'(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LastCnt   = CNT_W'(SETTLE_CYCLES + 2);
`else
    localparam logic [CNT_W-1:0] LastCnt   = CNT_W'(SETTLE_CYCLES);
`endif

    typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]     table_q, table_d;
    logic [TW-1:0]     exp_q, exp_d;
    logic              match_q, match_d;
    logic [N_IN-1:0]   fmi_q, fmi_d;
`ifdef TT_SWEEP_MAJORITY_EN
    logic [1:0]        samp_q, samp_d;
`endif

    // Lowest differing bit wins; an all-zero difference yields index 0.
    function automatic logic [N_IN-1:0] lowest_set(input logic [TW-1:0] v);
        logic [N_IN-1:0] r;
        r = '0;
        for (int i = TW - 1; i >= 0; i--) begin
            if (v[i]) r = N_IN'(i);
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        exp_d   = exp_q;
        match_d = match_q;
        fmi_d   = fmi_q;
`ifdef TT_SWEEP_MAJORITY_EN
        samp_d  = samp_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StDrive;
                    idx_d   = '0;
                    cnt_d   = '0;
                    table_d = '0;
                    exp_d   = expected;
                    match_d = 1'b0;
                end
            end
            StDrive: begin
                cnt_d = cnt_q + 1'b1;
`ifdef TT_SWEEP_MAJORITY_EN
                if (cnt_q == SampleCnt) samp_d[0] = dut_out;
                if (cnt_q == SecondCnt) samp_d[1] = dut_out;
                if (cnt_q == LastCnt) begin
                    table_d[idx_q] = (samp_q[0] & samp_q[1]) | (samp_q[0] & dut_out)
                                   | (samp_q[1] & dut_out);
                end
`else
                if (cnt_q == LastCnt) table_d[idx_q] = dut_out;
`endif
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                        // Judge the table including the bit captured on this same edge.
                        match_d = (table_d == exp_q);
                        fmi_d   = lowest_set(table_d ^ exp_q);
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            table_q <= '0;
            exp_q   <= '0;
            match_q <= 1'b0;
            fmi_q   <= '0;
`ifdef TT_SWEEP_MAJORITY_EN
            samp_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            exp_q   <= exp_d;
            match_q <= match_d;
            fmi_q   <= fmi_d;
`ifdef TT_SWEEP_MAJORITY_EN
            samp_q  <= samp_d;
`endif
        end
    end

    // idx never wraps and is cleared on reset/start, so it doubles as the driven vector.
    assign dut_in             = idx_q;
    assign busy               = (state_q == StDrive);
    assign done               = (state_q == StDone);
    assign table_out          = table_q;
    assign match              = match_q;
    assign first_mismatch_idx = fmi_q;

endmodule

// File: tb/tb_tt_sweep_reader.sv
// Self-checking bench for tt_sweep_reader: table vectors, corner sequences and random tables
// checked against a truth-table reference model.
module tb_tt_sweep_reader;

    localparam int unsigned TW  = 8;
    localparam int unsigned S_A = 4;
    localparam int unsigned S_B = 0;
`ifdef TT_SWEEP_MAJORITY_EN
    localparam int unsigned EXTRA = 3;
    localparam logic [7:0]  GLITCH_TBL = 8'h80;
`else
    localparam int unsigned EXTRA = 1;
    localparam logic [7:0]  GLITCH_TBL = 8'h84;
`endif
    localparam int unsigned PER_A = S_A + EXTRA;
    localparam int unsigned PER_B = S_B + EXTRA;
    localparam int unsigned LAT_A = TW * PER_A;
    localparam int unsigned LAT_B = TW * PER_B;

    logic       clk, rst_n;
    logic       start_a, start_b;
    logic [7:0] exp_a, exp_b;
    logic [2:0] dut_in_a, dut_in_b;
    logic       dut_out_a, dut_out_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic [7:0] tbl_a, tbl_b;
    logic       match_a, match_b;
    logic [2:0] fmi_a, fmi_b;

    int         mode_a, mode_b;
    logic [7:0] lut_a, lut_b;
    logic       glitch_a;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;

    // Results of the last sweep on instance A
    logic [7:0] r_tbl;
    logic       r_match, r_busy_at_done, r_done_after;
    logic [2:0] r_fmi;
    int         r_done_rel, r_traj_err;

    // Netlist behaviours: 0 AND3, 1 XNOR(in0,in1)&in2, 2 constant 1, 3 arbitrary LUT
    function automatic logic f_eval(input int mode, input logic [7:0] lut, input int i);
        logic [2:0] v;
        v = 3'(i);
        case (mode)
            0:       return &v;
            1:       return ~(v[0] ^ v[1]) & v[2];
            2:       return 1'b1;
            default: return lut[v];
        endcase
    endfunction

    assign dut_out_a = f_eval(mode_a, lut_a, int'(dut_in_a)) ^ glitch_a;
    assign dut_out_b = f_eval(mode_b, lut_b, int'(dut_in_b));

    tt_sweep_reader #(.N_IN(3), .SETTLE_CYCLES(S_A), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a), .dut_in(dut_in_a),
        .dut_out(dut_out_a), .busy(busy_a), .done(done_a), .table_out(tbl_a),
        .match(match_a), .first_mismatch_idx(fmi_a)
    );

    tt_sweep_reader #(.N_IN(3), .SETTLE_CYCLES(S_B), .CNT_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b), .dut_in(dut_in_b),
        .dut_out(dut_out_b), .busy(busy_b), .done(done_b), .table_out(tbl_b),
        .match(match_b), .first_mismatch_idx(fmi_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    endtask

    task automatic model(input int mode, input logic [7:0] lut, input logic [7:0] expv,
                         output logic [7:0] tbl, output logic m, output logic [2:0] fmi);
        for (int i = 0; i < TW; i++) tbl[i] = f_eval(mode, lut, i);
        m   = (tbl == expv);
        fmi = 3'd0;
        for (int i = TW - 1; i >= 0; i--) if (tbl[i] != expv[i]) fmi = 3'(i);
    endtask

    // Runs one sweep on A; disturb re-pulses start at E0+10 and flips expected at E0+12.
    task automatic sweep_a(input int mode, input logic [7:0] lut, input logic [7:0] expv,
                           input bit disturb, input int glitch_k);
        int e0, k;
        mode_a = mode;
        lut_a  = lut;
        @(posedge clk); #1;
        start_a = 1'b1;
        exp_a   = expv;
        @(posedge clk); #1;
        e0 = cyc;
        start_a = 1'b0;
        r_done_rel = -1;
        r_traj_err = 0;
        r_busy_at_done = 1'bx;
        for (int n = 0; n < int'(LAT_A) + 20 && r_done_rel < 0; n++) begin
            k = cyc - e0;
            glitch_a = (k == glitch_k);
            if (disturb) begin
                if (k == 9) start_a = 1'b1;
                else if (k == 10) start_a = 1'b0;
                if (k == 12) exp_a = ~expv;
            end
            if (k < int'(LAT_A)) begin
                if (dut_in_a !== 3'(k / int'(PER_A)) || busy_a !== 1'b1 || done_a !== 1'b0)
                    r_traj_err++;
            end
            if (done_a === 1'b1) begin
                r_done_rel = k;
                r_busy_at_done = busy_a;
            end
            @(posedge clk); #1;
        end
        glitch_a = 1'b0;
        start_a  = 1'b0;
        r_done_after = done_a;
        r_tbl   = tbl_a;
        r_match = match_a;
        r_fmi   = fmi_a;
    endtask

    typedef struct {
        int         mode;
        logic [7:0] lut;
        logic [7:0] expv;
        logic [7:0] tbl;
        logic       m;
        logic [2:0] fmi;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] m_tbl, lut, expv;
        logic       m_m;
        logic [2:0] m_fmi;
        int         cnt, e0;

        vecs[0] = '{0, 8'h00, 8'h80, 8'h80, 1'b1, 3'd0};
        vecs[1] = '{1, 8'h00, 8'h41, 8'h90, 1'b0, 3'd0};
        vecs[2] = '{2, 8'h00, 8'hFF, 8'hFF, 1'b1, 3'd0};
        vecs[3] = '{0, 8'h00, 8'h00, 8'h80, 1'b0, 3'd7};
        vecs[4] = '{1, 8'h00, 8'h10, 8'h90, 1'b0, 3'd7};
        vecs[5] = '{1, 8'h00, 8'h98, 8'h90, 1'b0, 3'd3};
        vecs[6] = '{3, 8'h5A, 8'h5A, 8'h5A, 1'b1, 3'd0};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; exp_a = 8'h00; exp_b = 8'h00;
        mode_a = 0; mode_b = 2; lut_a = 8'h00; lut_b = 8'h00; glitch_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", {busy_a, done_a, dut_in_a, tbl_a, match_a, fmi_a}, 32'h0);
        check("reset_b", {busy_b, done_b, dut_in_b, tbl_b, match_b, fmi_b}, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            sweep_a(vecs[i].mode, vecs[i].lut, vecs[i].expv, 1'b0, -1);
            check($sformatf("vec%0d_table", i), r_tbl, vecs[i].tbl);
            check($sformatf("vec%0d_match", i), r_match, vecs[i].m);
            check($sformatf("vec%0d_fmi", i), r_fmi, vecs[i].fmi);
            check($sformatf("vec%0d_latency", i), r_done_rel, LAT_A);
            check($sformatf("vec%0d_busy_at_done", i), r_busy_at_done, 1'b0);
            check($sformatf("vec%0d_done_one_cycle", i), r_done_after, 1'b0);
            check($sformatf("vec%0d_dut_in_steps", i), r_traj_err, 0);
            check($sformatf("vec%0d_dut_in_hold", i), dut_in_a, 3'd7);
        end

        // Start re-pulse and expected change mid-sweep are both ignored
        sweep_a(0, 8'h00, 8'h80, 1'b1, -1);
        check("disturb_latency", r_done_rel, LAT_A);
        check("disturb_table", r_tbl, 8'h80);
        check("disturb_match", r_match, 1'b1);
        check("disturb_steps", r_traj_err, 0);
        cnt = 0;
        repeat (2 * PER_A) begin
            @(posedge clk); #1;
            if (busy_a !== 1'b0) cnt++;
        end
        check("disturb_no_queue", cnt, 0);

        // Glitch on the first sample of vector 2
        sweep_a(0, 8'h00, 8'h80, 1'b0, 2 * PER_A + S_A);
        check("glitch_table", r_tbl, GLITCH_TBL);
        check("glitch_latency", r_done_rel, LAT_A);

        // Reset mid-sweep at idx 3
        mode_a = 2;
        @(posedge clk); #1;
        start_a = 1'b1; exp_a = 8'hFF;
        @(posedge clk); #1;
        e0 = cyc; start_a = 1'b0;
        while (cyc - e0 < 3 * int'(PER_A) + 1) begin
            @(posedge clk); #1;
        end
        check("pre_reset_idx", dut_in_a, 3'd3);
        check("pre_reset_table", tbl_a, 8'h07);
        rst_n = 1'b0;
        #1;
        check("async_reset", {busy_a, dut_in_a, tbl_a, done_a}, 32'h0);
        cnt = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done_a !== 1'b0) cnt++;
        end
        rst_n = 1'b1;
        repeat (LAT_A + 4) begin
            @(posedge clk); #1;
            if (done_a !== 1'b0 || busy_a !== 1'b0) cnt++;
        end
        check("reset_no_done", cnt, 0);
        sweep_a(0, 8'h00, 8'h80, 1'b0, -1);
        check("post_reset_table", r_tbl, 8'h80);
        check("post_reset_match", r_match, 1'b1);
        check("post_reset_latency", r_done_rel, LAT_A);

        // Random tables against the reference model
        for (int i = 0; i < 12; i++) begin
            lut  = 8'($urandom);
            expv = ($urandom_range(0, 1) == 1) ? lut : 8'($urandom);
            model(3, lut, expv, m_tbl, m_m, m_fmi);
            sweep_a(3, lut, expv, 1'b0, -1);
            check($sformatf("rand%0d_table", i), r_tbl, m_tbl);
            check($sformatf("rand%0d_match", i), r_match, m_m);
            check($sformatf("rand%0d_fmi", i), r_fmi, m_fmi);
            check($sformatf("rand%0d_latency", i), r_done_rel, LAT_A);
        end

        // Zero settle cycles, constant-1 netlist on instance B
        mode_b = 2;
        @(posedge clk); #1;
        start_b = 1'b1; exp_b = 8'hFF;
        @(posedge clk); #1;
        e0 = cyc; start_b = 1'b0;
        cnt = -1;
        for (int n = 0; n < int'(LAT_B) + 20 && cnt < 0; n++) begin
            if (done_b === 1'b1) cnt = cyc - e0;
            else begin
                @(posedge clk); #1;
            end
        end
        check("s0_latency", cnt, LAT_B);
        check("s0_table", tbl_b, 8'hFF);
        check("s0_match", match_b, 1'b1);
        check("s0_fmi", fmi_b, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tt_sweep_reader.md
Name: tt_sweep_reader

Overview:
- Sequential truth-table reader for combinational gate-level logic netlists (e.g. 3-input NOR/NOT designs addressed by hex truth table).
- Drives every input combination into the device under test (DUT) and holds each one for a settle interval.
- Samples the DUT output and assembles the measured truth table, then compares it with an expected hex code.
- Sits in the circuit-scoring test harness, on the stimulus/readback side of the logic netlist.

Parameters:
- N_IN, 3, number of DUT inputs. Table width is TW = 2^N_IN.
- SETTLE_CYCLES, 4, extra hold cycles per vector before sampling (0 allowed).
- CNT_W, 8, settle counter width. Must satisfy SETTLE_CYCLES+2 < 2^CNT_W.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, sweep request; sampled only in IDLE.
- expected, input, TW, expected truth table; latched when start is accepted.
- dut_in, output, N_IN, vector driven to DUT; bit k drives DUT input k.
- dut_out, input, 1, DUT output.
- busy, output, 1, high while a sweep is in progress.
- done, output, 1, one-cycle pulse when the sweep completes.
- table_out, output, TW, measured table; bit i = dut_out sampled while dut_in == i.
- match, output, 1, table_out == latched expected; valid from done onward.
- first_mismatch_idx, output, N_IN, lowest index i where the tables differ; 0 when match=1.

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of state:
  - state=IDLE
  - dut_in=0, busy=0, done=0
  - table_out=0, match=0, first_mismatch_idx=0
  - idx=0, cnt=0
- States: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 at an edge → DRIVE.
  - At that edge: busy=1, idx=0, dut_in=0, cnt=0, table_out cleared to 0, expected latched, match cleared to 0.
- DRIVE:
  - dut_in = idx (held stable); cnt increments each cycle.
  - At the edge where cnt==SETTLE_CYCLES: table_out[idx] ← dut_out.
    - If idx == TW-1 → DONE.
    - Otherwise idx+1, cnt=0.
  - Each vector occupies SETTLE_CYCLES+1 cycles.
- DONE:
  - One cycle with done=1, busy=0.
  - match and first_mismatch_idx are registered from the final table on the edge entering DONE.
  - Next state: IDLE.
- Latency: start accepted at edge E0 → done high in the cycle after edge E0 + TW*(SETTLE_CYCLES+1).
- Results hold after a sweep:
  - table_out, match and first_mismatch_idx stay until the next accepted start.
  - dut_in holds the last vector (TW-1).
- start while busy or in DONE: ignored; no queueing.
- expected changes mid-sweep: ignored; the latched copy is used.
- idx wrap: never increments past TW-1.
- first_mismatch_idx: priority encoder over (table ^ expected), lowest bit wins.

Optional Feature:
- Macro: TT_SWEEP_MAJORITY_EN.
- Defined:
  - Each vector is sampled at cnt == SETTLE_CYCLES, SETTLE_CYCLES+1 and SETTLE_CYCLES+2.
  - table_out[idx] = 2-of-3 majority of the three samples.
  - Each vector occupies SETTLE_CYCLES+3 cycles; latency becomes TW*(SETTLE_CYCLES+3).
- Undefined: single sample as described in Behaviour; no majority logic or sample registers are synthesized.

Test Plan:
- AND3 DUT model, N_IN=3, SETTLE_CYCLES=4, expected=0x80:
  - Pulse start → table_out=0x80, match=1, first_mismatch_idx=0.
  - done high exactly in the cycle after edge E0+40, for one cycle; busy low in that cycle.
- XNOR(in0,in1)&in2 DUT model (table 0x90), expected=0x41:
  - → table_out=0x90, match=0, first_mismatch_idx=0.
  - Check dut_in steps 0..7, each held 5 cycles.
- SETTLE_CYCLES=0, constant-1 DUT, expected=0xFF:
  - → done after 8 cycles, table_out=0xFF, match=1.
- Re-pulse start at E0+10, and change expected at E0+12:
  - → sweep unaffected, done at the original cycle, result judged against the originally latched expected.
- Assert rst_n=0 mid-sweep at idx=3:
  - → immediately busy=0, dut_in=0, table_out=0, done never pulses.
  - A new start afterwards completes normally.
- With TT_SWEEP_MAJORITY_EN defined, AND3 DUT with a one-cycle glitch to 1 at the first sample of vector 2:
  - → table_out=0x80 still.
  - done after 8*7=56 cycles.
